// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath constants
package cpu_pkg;
   localparam int PC_WIDTH  = 10;
   localparam int RAS_DEPTH = 8;
endpackage

// File: rtl/pila_param.sv
// pila_param: parametrised return-address stack with occupancy and sticky error flags
module pila_param
   import cpu_pkg::*;
#(
   parameter int WIDTH = PC_WIDTH,
   parameter int DEPTH = RAS_DEPTH,
   localparam int PW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] inpush,
   input  logic             clr_err,
   output logic [WIDTH-1:0] outpop,
   output logic [PW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    sp;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    wr_idx;
   logic             wr_en;
   logic             ovf_set;
   logic             unf_set;

   assign count   = sp;
   assign empty   = sp == '0;
   assign full    = sp == PW'(DEPTH);
   assign top_idx = AW'(sp - PW'(1));
   assign wr_idx  = (pop && !empty) ? top_idx : AW'(sp);
   assign wr_en   = push && (pop || !full);
   assign ovf_set = push && !pop && full;
   assign unf_set = pop && empty;
   assign outpop  = empty ? '0 : mem[top_idx];

   // Stack pointer with saturation at 0 and DEPTH; error flags are sticky and setting beats clearing
   always_ff @(posedge clk) begin
      if (!reset) begin
         sp        <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push && !pop && !full)
            sp <= sp + PW'(1);
         else if (pop && !push && !empty)
            sp <= sp - PW'(1);
         else if (push && pop && empty)
            sp <= PW'(1);
         overflow  <= (overflow && !clr_err) || ovf_set;
         underflow <= (underflow && !clr_err) || unf_set;
      end
   end

   // Entry storage is left unreset; push writes above the top, push+pop replaces the top
   always_ff @(posedge clk) begin
      if (reset && wr_en)
         mem[wr_idx] <= inpush;
   end
endmodule

// File: tb/tb_pila_param.sv
// tb_pila_param: randomized and directed checks of pila_param against a queue-based model
module tb_pila_param;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        push8, pop8, clr8;
   logic [9:0]  in8, out8;
   logic [3:0]  count8;
   logic        empty8, full8, ovf8, unf8;
   logic        push2, pop2, clr2;
   logic [15:0] in2, out2;
   logic [1:0]  count2;
   logic        empty2, full2, ovf2, unf2;

   int          n_chk = 0;
   int          n_pass = 0;
   bit          sel;
   int          md;
   logic [15:0] mask;
   logic [15:0] q[$];
   bit          m_ovf, m_unf;

   always #5 clk = ~clk;

   pila_param u8 (
      .clk(clk), .reset(rst_n), .push(push8), .pop(pop8), .inpush(in8), .clr_err(clr8),
      .outpop(out8), .count(count8), .empty(empty8), .full(full8),
      .overflow(ovf8), .underflow(unf8)
   );

   pila_param #(.WIDTH(16), .DEPTH(2)) u2 (
      .clk(clk), .reset(rst_n), .push(push2), .pop(pop2), .inpush(in2), .clr_err(clr2),
      .outpop(out2), .count(count2), .empty(empty2), .full(full2),
      .overflow(ovf2), .underflow(unf2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_step(input bit ps, input bit pp, input logic [15:0] d, input bit cl);
      bit e = q.size() == 0;
      bit f = q.size() == md;
      if (cl) begin
         m_ovf = 0;
         m_unf = 0;
      end
      if (ps && pp) begin
         if (e) begin
            m_unf = 1;
            q.push_back(d & mask);
         end else q[q.size()-1] = d & mask;
      end else if (ps) begin
         if (f) m_ovf = 1;
         else q.push_back(d & mask);
      end else if (pp) begin
         if (e) m_unf = 1;
         else void'(q.pop_back());
      end
   endtask

   task automatic verify();
      logic [31:0] top = q.size() ? 32'(q[q.size()-1]) : 32'd0;
      chk("outpop",    sel ? 32'(out2)   : 32'(out8),   top);
      chk("count",     sel ? 32'(count2) : 32'(count8), 32'(q.size()));
      chk("empty",     sel ? 32'(empty2) : 32'(empty8), 32'(q.size() == 0));
      chk("full",      sel ? 32'(full2)  : 32'(full8),  32'(q.size() == md));
      chk("overflow",  sel ? 32'(ovf2)   : 32'(ovf8),   32'(m_ovf));
      chk("underflow", sel ? 32'(unf2)   : 32'(unf8),   32'(m_unf));
   endtask

   task automatic cycle(input bit ps, input bit pp, input logic [15:0] d, input bit cl, input bit rs);
      rst_n = !rs;
      push8 = !sel && ps; pop8 = !sel && pp; clr8 = !sel && cl; in8 = d[9:0];
      push2 = sel && ps;  pop2 = sel && pp;  clr2 = sel && cl;  in2 = d;
      @(posedge clk);
      if (rs) begin
         q.delete();
         m_ovf = 0;
         m_unf = 0;
      end else model_step(ps, pp, d, cl);
      #1;
      verify();
   endtask

   task automatic select(input bit s);
      sel  = s;
      md   = s ? 2 : 8;
      mask = s ? 16'hFFFF : 16'h03FF;
      cycle(1, 0, 16'h0055, 0, 1);
      cycle(1, 0, 16'h0055, 0, 1);
   endtask

   initial begin
      select(0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 16'h011 * 16'(i + 1), 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 16'h0, 0, 0);
      for (int i = 0; i < 9; i++) cycle(1, 0, 16'h040 + 16'(i), 0, 0);
      cycle(0, 0, 16'h0, 0, 0);
      cycle(0, 0, 16'h0, 1, 0);
      for (int i = 0; i < 8; i++) cycle(0, 1, 16'h0, 0, 0);
      cycle(0, 1, 16'h0, 0, 0);
      cycle(0, 1, 16'h0, 1, 0);
      cycle(0, 0, 16'h0, 1, 0);
      cycle(1, 0, 16'h100, 0, 0);
      cycle(1, 1, 16'h2AA, 0, 0);
      for (int i = 0; i < 7; i++) cycle(1, 0, 16'h300 + 16'(i), 0, 0);
      cycle(1, 1, 16'h155, 0, 0);
      cycle(1, 1, 16'h0AA, 0, 0);
      for (int i = 0; i < 8; i++) cycle(0, 1, 16'h0, 0, 0);
      cycle(1, 1, 16'h3C3, 0, 0);
      for (int i = 0; i < 5; i++) cycle(1, 0, 16'h200 + 16'(i), 0, 0);
      cycle(0, 0, 16'h0, 0, 1);
      cycle(0, 0, 16'h0, 0, 0);
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 16'($urandom),
               $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2);
      select(1);
      cycle(1, 0, 16'hA011, 0, 0);
      cycle(1, 0, 16'hB022, 0, 0);
      cycle(1, 0, 16'hC033, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 16'h0, 0, 0);
      cycle(1, 1, 16'hBEEF, 0, 0);
      for (int i = 0; i < 300; i++)
         cycle($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 45, 16'($urandom),
               $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
